// File: rtl/dram_key_sbox_readback.sv
// Key/SBOX DRAM readback checker: reads every word back through the
// controller handshake and compares it lane by lane with the generator.
module dram_key_sbox_readback #(
  parameter int LAST_ADDR   = 63,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          START,
  output logic          RD_EN,
  output logic [5:0]    ADDR,
  input  logic          rd_done,
  input  logic [1023:0] RBL_DATA,
  output logic [5:0]    EXP_ADDR,
  input  logic [1023:0] EXP_DATA,
  output logic          DONE,
  output logic          PASS,
  output logic          TIMEOUT,
  output logic [6:0]    ERR_CNT,
  output logic [5:0]    FIRST_ERR_ADDR,
  output logic [15:0]   FIRST_ERR_LANES
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [5:0]    LAST  = 6'(LAST_ADDR);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CMP
  } state_e;

  state_e state_q, state_d;

  logic [5:0]    addr_q, addr_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          to_q, to_d;
  logic [6:0]    err_q, err_d;
  logic [5:0]    fea_q, fea_d;
  logic [15:0]   fel_q, fel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1023:0] cap_q, cap_d;
  logic [15:0]   mask;
  logic          rd_en;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (START) state_d = S_REQ;
      S_REQ: begin
        if (rd_done)             state_d = S_CMP;
        else if (cnt_q == LIMIT) state_d = S_IDLE;
      end
      S_CMP: state_d = (addr_q == LAST) ? S_IDLE : S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == S_REQ);
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < 16; i++)
      mask[i] = (cap_q[64*i +: 64] != EXP_DATA[64*i +: 64]);
  end

  always_comb begin
    addr_d = addr_q;
    done_d = done_q;
    pass_d = pass_q;
    to_d   = to_q;
    err_d  = err_q;
    fea_d  = fea_q;
    fel_d  = fel_q;
    cnt_d  = cnt_q;
    cap_d  = cap_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d = '0;
          done_d = 1'b0;
          pass_d = 1'b0;
          to_d   = 1'b0;
          err_d  = '0;
          fea_d  = '0;
          fel_d  = '0;
          cnt_d  = '0;
        end
      end
      S_REQ: begin
        // a response on the limit cycle still counts as a good read
        if (rd_done) begin
          cap_d = RBL_DATA;
        end else if (cnt_q == LIMIT) begin
          to_d   = 1'b1;
          done_d = 1'b1;
          pass_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CMP: begin
        if (mask != '0) begin
          if (err_q != 7'h7f) err_d = err_q + 7'd1;
          if (err_q == '0) begin
            fea_d = addr_q;
            fel_d = mask;
          end
        end
        if (addr_q == LAST) begin
          done_d = 1'b1;
          pass_d = (err_d == '0);
        end else begin
          addr_d = addr_q + 6'd1;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      addr_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      to_q   <= 1'b0;
      err_q  <= '0;
      fea_q  <= '0;
      fel_q  <= '0;
      cnt_q  <= '0;
      cap_q  <= '0;
    end else begin
      addr_q <= addr_d;
      done_q <= done_d;
      pass_q <= pass_d;
      to_q   <= to_d;
      err_q  <= err_d;
      fea_q  <= fea_d;
      fel_q  <= fel_d;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
    end
  end

  assign RD_EN           = rd_en;
  assign ADDR            = addr_q;
  assign EXP_ADDR        = addr_q;
  assign DONE            = done_q;
  assign PASS            = pass_q;
  assign TIMEOUT         = to_q;
  assign ERR_CNT         = err_q;
  assign FIRST_ERR_ADDR  = fea_q;
  assign FIRST_ERR_LANES = fel_q;

endmodule
